// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front-end conditioning for raw board inputs. Each active-low push-button is
// synchronized, debounced and turned into an active-high level plus one-cycle
// press/release pulses. The slide switches are synchronized and given a flag
// that reports when the synchronized value has held still long enough.
//
// Ports:
//   Clk          in   system clock (single domain)
//   Reset        in   synchronous, active-high reset
//   Key_n        in   [N_KEYS]    raw buttons, active-low, asynchronous
//   SW           in   [SW_WIDTH]  raw switches, asynchronous
//   Key_level    out  [N_KEYS]    debounced button state, 1 = pressed
//   Key_press    out  [N_KEYS]    one-cycle pulse on debounced 0->1
//   Key_release  out  [N_KEYS]    one-cycle pulse on debounced 1->0
//   SW_out       out  [SW_WIDTH]  two-flop-synchronized switch value
//   SW_stable    out              SW_out unchanged for >= DEBOUNCE_CYCLES edges
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,  // legal range >= 2
  parameter int N_KEYS          = 3,
  parameter int SW_WIDTH        = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [N_KEYS-1:0]   Key_n,
  input  logic [SW_WIDTH-1:0] SW,
  output logic [N_KEYS-1:0]   Key_level,
  output logic [N_KEYS-1:0]   Key_press,
  output logic [N_KEYS-1:0]   Key_release,
  output logic [SW_WIDTH-1:0] SW_out,
  output logic                SW_stable
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Key path state
  logic [N_KEYS-1:0] key_s1_q, key_s2_q;
  logic [N_KEYS-1:0] level_q,   level_d;
  logic [N_KEYS-1:0] press_q,   press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [CW-1:0]     cnt_d [N_KEYS];

  // Switch path state
  logic [SW_WIDTH-1:0] sw_s1_q, sw_out_q;
  logic [CW-1:0]       scnt_q, scnt_d;
  logic                stable_q, stable_d;
  logic                sw_changed;

  // ---------------------------------------------------------------------------
  // Debounce next-state. A key's counter only runs while the synchronized
  // input disagrees with the accepted level; any agreement (a bounce back)
  // zeroes it so the whole window must be seen again.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    cnt_d     = '{default: '0};
    for (int i = 0; i < N_KEYS; i++) begin
      if (key_s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          // Accept the new value; the counter returns to 0 via the default.
          level_d[i]   = key_s2_q[i];
          press_d[i]   = key_s2_q[i];
          release_d[i] = ~key_s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Switch stability. The flag is registered from the saturated count, so it
  // rises DEBOUNCE_CYCLES edges after the last SW_out change and drops in the
  // same edge SW_out takes a new value.
  // ---------------------------------------------------------------------------
  always_comb begin
    sw_changed = (sw_s1_q != sw_out_q);
    scnt_d     = scnt_q;
    stable_d   = 1'b0;
    if (sw_changed) begin
      scnt_d = '0;
    end else begin
      if (scnt_q != CNT_MAX) begin
        scnt_d = scnt_q + 1'b1;
      end
      stable_d = (scnt_q == CNT_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      // NOTE: the per-key counters are state, not storage, so they are reset
      // too; a partial count must never survive into the next run.
      cnt_q     <= '{default: '0};
      sw_s1_q   <= '0;
      sw_out_q  <= '0;
      scnt_q    <= '0;
      stable_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // this is what makes s1 -> s2 a real two-stage synchronizer.
      key_s1_q  <= ~Key_n;
      key_s2_q  <= key_s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
      sw_s1_q   <= SW;
      sw_out_q  <= sw_s1_q;
      scnt_q    <= scnt_d;
      stable_q  <= stable_d;
    end
  end

  assign Key_level   = level_q;
  assign Key_press   = press_q;
  assign Key_release = release_q;
  assign SW_out      = sw_out_q;
  assign SW_stable   = stable_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4. A timeline
// table drives clean presses/releases and switch changes; hand-written
// sequences cover key bounce and a reset that lands mid-count.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [2:0] Key_n;
  logic [7:0] SW;
  logic [2:0] Key_level, Key_press, Key_release;
  logic [7:0] SW_out;
  logic       SW_stable;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .N_KEYS         (3),
    .SW_WIDTH       (8)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Key_n      (Key_n),
    .SW         (SW),
    .Key_level  (Key_level),
    .Key_press  (Key_press),
    .Key_release(Key_release),
    .SW_out     (SW_out),
    .SW_stable  (SW_stable)
  );

  always #5 Clk = ~Clk;

  // One timeline step: hold the inputs for n edges, then compare.
  typedef struct {
    int         n;
    logic       rst;
    logic [2:0] key_n;
    logic [7:0] sw;
    logic [2:0] lvl;
    logic [2:0] prs;
    logic [2:0] rel;
    logic [7:0] swo;
    logic       stb;
  } vec_t;

  localparam int NVEC = 21;
  vec_t tbl [NVEC];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    Reset = 1'b1;
    Key_n = 3'b111;
    SW    = 8'h00;

    //          n  rst key_n   sw     lvl     prs     rel     swo    stb
    tbl[0]  = '{2, 1, 3'b111, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0}; // in reset
    tbl[1]  = '{1, 0, 3'b111, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b0}; // r1
    tbl[2]  = '{3, 0, 3'b111, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1}; // r4 stable
    tbl[3]  = '{1, 0, 3'b110, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1}; // r5 key0 sampled
    tbl[4]  = '{4, 0, 3'b110, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1}; // r9 one short
    tbl[5]  = '{1, 0, 3'b110, 8'h00, 3'b001, 3'b001, 3'b000, 8'h00, 1'b1}; // r10 accept
    tbl[6]  = '{1, 0, 3'b110, 8'h00, 3'b001, 3'b000, 3'b000, 8'h00, 1'b1}; // pulse gone
    tbl[7]  = '{5, 0, 3'b111, 8'h00, 3'b001, 3'b000, 3'b000, 8'h00, 1'b1}; // r16 one short
    tbl[8]  = '{1, 0, 3'b111, 8'h00, 3'b000, 3'b000, 3'b001, 8'h00, 1'b1}; // r17 release
    tbl[9]  = '{1, 0, 3'b111, 8'h00, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1};
    tbl[10] = '{1, 0, 3'b111, 8'hA5, 3'b000, 3'b000, 3'b000, 8'h00, 1'b1}; // SW in s1
    tbl[11] = '{1, 0, 3'b111, 8'hA5, 3'b000, 3'b000, 3'b000, 8'hA5, 1'b0}; // SW_out moves
    tbl[12] = '{3, 0, 3'b111, 8'hA5, 3'b000, 3'b000, 3'b000, 8'hA5, 1'b0}; // one short
    tbl[13] = '{1, 0, 3'b111, 8'hA5, 3'b000, 3'b000, 3'b000, 8'hA5, 1'b1}; // +4 edges
    tbl[14] = '{1, 0, 3'b111, 8'hA4, 3'b000, 3'b000, 3'b000, 8'hA5, 1'b1};
    tbl[15] = '{1, 0, 3'b111, 8'hA4, 3'b000, 3'b000, 3'b000, 8'hA4, 1'b0}; // drops at once
    tbl[16] = '{5, 0, 3'b000, 8'hA4, 3'b000, 3'b000, 3'b000, 8'hA4, 1'b1}; // all keys
    tbl[17] = '{1, 0, 3'b000, 8'hA4, 3'b111, 3'b111, 3'b000, 8'hA4, 1'b1};
    tbl[18] = '{1, 0, 3'b000, 8'hA4, 3'b111, 3'b000, 3'b000, 8'hA4, 1'b1};
    tbl[19] = '{6, 0, 3'b111, 8'hA4, 3'b000, 3'b000, 3'b111, 8'hA4, 1'b1}; // all release
    tbl[20] = '{1, 0, 3'b111, 8'hA4, 3'b000, 3'b000, 3'b000, 8'hA4, 1'b1};

    for (int i = 0; i < NVEC; i++) begin
      Reset = tbl[i].rst;
      Key_n = tbl[i].key_n;
      SW    = tbl[i].sw;
      for (int c = 0; c < tbl[i].n; c++) tick();
      check($sformatf("row%0d level", i),   32'(Key_level),   32'(tbl[i].lvl));
      check($sformatf("row%0d press", i),   32'(Key_press),   32'(tbl[i].prs));
      check($sformatf("row%0d release", i), 32'(Key_release), 32'(tbl[i].rel));
      check($sformatf("row%0d sw_out", i),  32'(SW_out),      32'(tbl[i].swo));
      check($sformatf("row%0d stable", i),  32'(SW_stable),   32'(tbl[i].stb));
    end

    // Bounce on key 1: low at k, high at k+2, low from k+3 -> accepted at k+8.
    for (int i = 0; i < 9; i++) begin
      Key_n = (i == 2) ? 3'b111 : 3'b101;
      tick();
      check($sformatf("bounce%0d level", i),   32'(Key_level),   32'((i == 8) ? 3'b010 : 3'b000));
      check($sformatf("bounce%0d press", i),   32'(Key_press),   32'((i == 8) ? 3'b010 : 3'b000));
      check($sformatf("bounce%0d release", i), 32'(Key_release), 32'(0));
    end
    tick();
    check("bounce after press",  32'(Key_press), 32'(0));
    check("bounce after level",  32'(Key_level), 32'(3'b010));

    // Release key 1 again: sampled on the first edge, level falls on the sixth.
    Key_n = 3'b111;
    for (int c = 0; c < 6; c++) tick();
    check("bounce release level", 32'(Key_level),   32'(0));
    check("bounce release pulse", 32'(Key_release), 32'(3'b010));

    // Reset lands mid-count on key 0 and the key stays held: the aborted
    // transition gives no pulse, the post-reset press arrives at k+8.
    for (int i = 0; i < 10; i++) begin
      Key_n = 3'b110;
      Reset = (i == 2);
      tick();
      if (i == 2) begin
        check("reset level",   32'(Key_level),   32'(0));
        check("reset press",   32'(Key_press),   32'(0));
        check("reset release", 32'(Key_release), 32'(0));
        check("reset sw_out",  32'(SW_out),      32'(0));
        check("reset stable",  32'(SW_stable),   32'(0));
      end
      check($sformatf("rst%0d level", i), 32'(Key_level), 32'((i >= 8) ? 3'b001 : 3'b000));
      check($sformatf("rst%0d press", i), 32'(Key_press), 32'((i == 8) ? 3'b001 : 3'b000));
    end
    Reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
